// File: rtl/uart_tx_buffer_pkg.sv
// uart_tx_buffer_pkg: shared FSM state encoding for the UART transmit buffer
package uart_tx_buffer_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/uart_tx_buffer_byte_fifo.sv
// byte_fifo: circular byte store with occupancy, full/empty, sticky overflow and registered read data
module byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clr_ovf,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_ovf;
  logic              w_push, w_pop;
  assign o_full     = r_count == (ADDR_W+1)'(DEPTH);
  assign o_empty    = r_count == '0;
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_count    = r_count;
  assign o_rd_data  = r_rd_data;
  assign o_overflow = r_ovf;
  // Storage array: no reset needed, contents are only read behind the count
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  // Pointers, occupancy, read register and overflow flag; a drop beats a clear
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + {ADDR_W'(0), w_push} - {ADDR_W'(0), w_pop};
      r_ovf   <= (i_push && o_full) ? 1'b1 : i_clr_ovf ? 1'b0 : r_ovf;
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: buffers received bytes and feeds them one by one to the UART transmitter
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_tx_busy,
  input  logic              i_clr_ovf,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx_start;
  logic             w_pop;
  assign w_pop      = (r_state == IDLE) && !o_empty && !i_tx_busy;
  assign o_tx_start = r_tx_start;
  byte_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (i_wr_valid),
    .i_pop     (w_pop),
    .i_clr_ovf (i_clr_ovf),
    .i_wr_data (i_wr_data),
    .o_rd_data (o_tx_data),
    .o_count   (o_count),
    .o_empty   (o_empty),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );
  // Drain FSM: pop, pulse start, then wait for the busy handshake or give up after the timeout
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE:
          if (w_pop) begin
            r_state    <= START;
            r_tx_start <= 1'b1;
          end
        START: begin
          r_cnt   <= CNT_W'(BUSY_TIMEOUT - 1);
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY:
          if (i_tx_busy) r_state <= WAIT_DONE;
          else if (r_cnt == '0) r_state <= IDLE;
          else r_cnt <= r_cnt - CNT_W'(1);
        WAIT_DONE:
          if (!i_tx_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: scoreboard bench with a queue-based buffer model and a behavioural transmitter
module tb_uart_tx_buffer;
  localparam int DEPTH = 16;
  logic       i_clk = 0, i_rst_n = 0, i_wr_valid = 0, i_tx_busy = 0, i_clr_ovf = 0;
  logic [7:0] i_wr_data = 0;
  logic [7:0] o_tx_data;
  logic       o_tx_start, o_empty, o_full, o_overflow;
  logic [4:0] o_count;
  int         checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         m_count = 0, cyc = 0, busy_left = 0, busy_len = 10, fell_cyc = -10, pending_exp = -1;
  bit         m_ovf = 0, auto_busy = 0, rand_len = 0, fell_next = 0;

  uart_tx_buffer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
    .i_tx_busy(i_tx_busy), .i_clr_ovf(i_clr_ovf), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every start pulse must carry the oldest outstanding byte
  always @(negedge i_clk)
    if (i_rst_n && o_tx_start) begin
      check("start_has_pending_byte", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        automatic logic [7:0] e = exp_q.pop_front();
        check("tx_data_order", int'(o_tx_data), int'(e));
      end
    end

  task automatic tick();
    bit drop;
    @(posedge i_clk);
    #1;
    cyc++;
    if (!i_rst_n) begin
      m_count = 0;
      m_ovf   = 0;
      exp_q.delete();
    end else begin
      drop = i_wr_valid && (m_count == DEPTH);
      if (i_wr_valid && !drop) begin
        exp_q.push_back(i_wr_data);
        m_count++;
      end
      m_ovf = drop ? 1'b1 : i_clr_ovf ? 1'b0 : m_ovf;
      if (o_tx_start) m_count--;
    end
    if (o_tx_start) starts.push_back(cyc);
    if (pending_exp == cyc) check("start_2_after_busy_fall", int'(o_tx_start), 1);
    check("count", int'(o_count), m_count);
    check("empty", int'(o_empty), int'(m_count == 0));
    check("full", int'(o_full), int'(m_count == DEPTH));
    check("overflow", int'(o_overflow), int'(m_ovf));
    if (cyc == fell_cyc + 1 && m_count > 0) pending_exp = cyc + 1;
    if (auto_busy) begin
      if (busy_left > 0) begin
        i_tx_busy = 1;
        busy_left--;
        if (busy_left == 0) fell_next = 1;
      end else begin
        i_tx_busy = 0;
        if (fell_next) begin
          fell_cyc  = cyc;
          fell_next = 0;
        end
      end
      if (o_tx_start) busy_left = rand_len ? int'($urandom_range(0, 12)) : busy_len;
    end
    i_wr_valid = 0;
    i_clr_ovf  = 0;
  endtask

  task automatic push(logic [7:0] d);
    i_wr_valid = 1;
    i_wr_data  = d;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (exp_q.size() > 0 || m_count > 0 || busy_left > 0); i++) tick();
    check("drain_complete", exp_q.size(), 0);
    repeat (20) tick();
  endtask

  initial begin
    int k;
    repeat (3) tick();
    check("reset_tx_data", int'(o_tx_data), 0);
    check("reset_tx_start", int'(o_tx_start), 0);
    i_rst_n = 1;
    // Single byte latency with an idle, never-responding transmitter
    while (cyc < 10) tick();
    push(8'h41);
    check("latency_no_early_start", int'(o_tx_start), 0);
    tick();
    check("latency_start_k2", int'(o_tx_start), 1);
    check("latency_data", int'(o_tx_data), 8'h41);
    repeat (14) tick();
    // Burst of five with a 10-cycle busy transmitter
    auto_busy = 1;
    busy_len  = 10;
    for (int i = 1; i <= 5; i++) push(8'(i));
    drain();
    // Fill while busy, overflow, set-wins-over-clear, then clear
    auto_busy = 0;
    i_tx_busy = 1;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    check("full_after_16", int'(o_full), 1);
    push(8'hEE);
    check("overflow_after_17", int'(o_overflow), 1);
    i_clr_ovf = 1;
    push(8'hEF);
    check("overflow_set_wins", int'(o_overflow), 1);
    i_clr_ovf = 1;
    tick();
    check("overflow_cleared", int'(o_overflow), 0);
    auto_busy = 1;
    drain();
    // Busy never rises: timeout, then the second byte
    auto_busy = 0;
    i_tx_busy = 0;
    starts.delete();
    k = cyc + 1;
    tick();
    push(8'hAA);
    push(8'hBB);
    repeat (14) tick();
    check("timeout_start_count", starts.size(), 2);
    if (starts.size() >= 2) begin
      check("timeout_first_start", starts[0] - k, 2);
      check("timeout_second_start", starts[1] - k, 12);
    end
    repeat (5) tick();
    // Asynchronous reset while waiting for the transmitter to finish
    auto_busy = 1;
    busy_len  = 20;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    repeat (4) tick();
    #2;
    i_rst_n   = 0;
    auto_busy = 0;
    busy_left = 0;
    fell_next = 0;
    i_tx_busy = 0;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 0;
    #1;
    check("async_rst_tx_data", int'(o_tx_data), 0);
    check("async_rst_tx_start", int'(o_tx_start), 0);
    check("async_rst_count", int'(o_count), 0);
    check("async_rst_empty", int'(o_empty), 1);
    check("async_rst_full", int'(o_full), 0);
    check("async_rst_overflow", int'(o_overflow), 0);
    repeat (2) tick();
    i_rst_n = 1;
    starts.delete();
    repeat (20) tick();
    check("no_start_after_reset", starts.size(), 0);
    // Push and pop in the same cycle at occupancy five
    i_tx_busy = 1;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    auto_busy = 1;
    busy_len  = 6;
    i_tx_busy = 0;
    push(8'h77);
    check("simul_push_pop_count", int'(o_count), 5);
    check("simul_push_pop_start", int'(o_tx_start), 1);
    drain();
    // Randomized traffic with random transmitter busy lengths
    rand_len = 1;
    for (int i = 0; i < 400; i++) begin
      i_wr_valid = ($urandom_range(0, 2) == 0);
      i_wr_data  = 8'($urandom);
      i_clr_ovf  = ($urandom_range(0, 15) == 0);
      tick();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
